// File: rtl/verilab_i2c_pkg.sv
// rtl/verilab_i2c_pkg.sv - shared types and constants for the byte-level I2C master
package verilab_i2c_pkg;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } i2c_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_RESP
  } i2c_state_e;

  typedef logic [1:0] quarter_t;

  localparam quarter_t Q0 = 2'd0;
  localparam quarter_t Q1 = 2'd1;
  localparam quarter_t Q2 = 2'd2;
  localparam quarter_t Q3 = 2'd3;

endpackage

// File: rtl/verilab_i2c_tick_gen.sv
// rtl/verilab_i2c_tick_gen.sv - quarter-period tick counter with SCL stretch hold
module verilab_i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       stretch_hold,
  output logic       quarter_done,
  output logic [1:0] quarter
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign quarter_done = enable && !stretch_hold && (cnt == LAST);

  // A stretched quarter restarts its count once the slave lets SCL go high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (!enable) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (stretch_hold) begin
      cnt     <= '0;
    end else if (quarter_done) begin
      cnt     <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/verilab_i2c_master.sv
// rtl/verilab_i2c_master.sv - byte-level I2C master sequencing the core-side pad signals
module verilab_i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       ack_in,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       ack_out,
  output logic       rsp_err,
  output logic       arb_lost,
  output logic       bus_owned,
  input  logic       core_i2c_scl_in,
  output logic       core_i2c_scl_out,
  output logic       core_i2c_scl_en,
  input  logic       core_i2c_sda_in,
  output logic       core_i2c_sda_out,
  output logic       core_i2c_sda_en
);

  import verilab_i2c_pkg::*;

  i2c_state_e state, state_nxt;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       is_read, ack_bit, sample, err_q, arb_q;
  logic       active, quarter_done, accept, q2_end, q3_end;
  logic       arb_hit, last_bit, data_drive;
  logic [1:0] quarter;

  assign active    = state inside {ST_START, ST_BIT, ST_ACK, ST_STOP};
  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign q2_end    = quarter_done && (quarter == Q2);
  assign q3_end    = quarter_done && (quarter == Q3);
  assign last_bit  = (bit_cnt == 3'(BITS_PER_BYTE - 1));
  assign arb_hit   = (state == ST_BIT) && !is_read && shreg[7] && q2_end && !core_i2c_sda_in;

  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign arb_lost  = rsp_valid && arb_q;

  assign core_i2c_scl_out = 1'b0;
  assign core_i2c_sda_out = 1'b0;

  verilab_i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (active),
    .stretch_hold (active && !core_i2c_scl_en && !core_i2c_scl_in),
    .quarter_done (quarter_done),
    .quarter      (quarter)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (i2c_cmd_e'(cmd) == CMD_START)     state_nxt = ST_START;
          else if (!bus_owned)                  state_nxt = ST_RESP;
          else if (i2c_cmd_e'(cmd) == CMD_STOP) state_nxt = ST_STOP;
          else                                  state_nxt = ST_BIT;
        end
      end
      ST_START, ST_STOP, ST_ACK: if (q3_end) state_nxt = ST_RESP;
      ST_BIT: begin
        if (arb_hit)                 state_nxt = ST_RESP;
        else if (q3_end && last_bit) state_nxt = ST_ACK;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign data_drive = (state == ST_BIT) ? (!is_read && !shreg[7]) : (is_read && !ack_bit);

  // Between commands an owned bus keeps SCL low so no slave sees a spurious clock.
  always_comb begin
    core_i2c_scl_en = bus_owned;
    core_i2c_sda_en = 1'b0;
    case (state)
      ST_START: begin
        core_i2c_scl_en = (quarter == Q0) ? bus_owned : (quarter == Q3);
        core_i2c_sda_en = quarter inside {Q2, Q3};
      end
      ST_BIT, ST_ACK: begin
        core_i2c_scl_en = quarter inside {Q0, Q3};
        core_i2c_sda_en = data_drive;
      end
      ST_STOP: begin
        core_i2c_scl_en = (quarter == Q0);
        core_i2c_sda_en = quarter inside {Q0, Q1};
      end
      default: ;
    endcase
  end

  // The Q2 sample is shifted in at Q3 so SDA never changes while SCL is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
      ack_bit   <= 1'b0;
      sample    <= 1'b0;
      err_q     <= 1'b0;
      arb_q     <= 1'b0;
      rd_data   <= '0;
      ack_out   <= 1'b0;
      bus_owned <= 1'b0;
    end else begin
      if (accept) begin
        shreg   <= wr_data;
        bit_cnt <= '0;
        is_read <= (i2c_cmd_e'(cmd) == CMD_READ);
        ack_bit <= ack_in;
        arb_q   <= 1'b0;
        err_q   <= (i2c_cmd_e'(cmd) != CMD_START) && !bus_owned;
      end
      if (q2_end) sample <= core_i2c_sda_in;
      case (state)
        ST_START: if (q3_end) bus_owned <= 1'b1;
        ST_STOP:  if (q3_end) bus_owned <= 1'b0;
        ST_BIT: begin
          if (arb_hit) begin
            arb_q     <= 1'b1;
            bus_owned <= 1'b0;
          end else if (q3_end) begin
            shreg   <= {shreg[6:0], sample};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ST_ACK: begin
          if (q2_end && !is_read)     ack_out <= core_i2c_sda_in;
          else if (q3_end && is_read) rd_data <= shreg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/verilab_i2c_master.md
Name: verilab_i2c_master

Overview:
- Byte-level I2C master controller that sequences the core-side I2C pad signals of the pad ring. These are the scl/sda pairs: `_in` comes from the pad, `_out`/`_en` go to the pad.
- Accepts START, STOP, WRITE and READ commands over a valid/ready interface and returns one response per command.
- Generates SCL timing, tolerates slave clock stretching and detects arbitration loss.
- Sits in the core, between software-visible registers and the pad block.

Parameters:
- CLK_DIV, 250, clk cycles per quarter SCL period (min 2); bit time = 4*CLK_DIV plus stretch.

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  controller can accept a command.
- cmd  input  2  command code: 0=START, 1=STOP, 2=WRITE, 3=READ.
- wr_data  input  8  byte for WRITE; captured on accept.
- ack_in  input  1  ACK bit master sends after READ (0=ACK, 1=NACK); captured on accept.
- rsp_valid  output  1  one-cycle response pulse.
- rd_data  output  8  byte received by READ; held until next READ response.
- ack_out  output  1  ACK bit sampled from slave after WRITE (0=ACK).
- rsp_err  output  1  command illegal in current bus state.
- arb_lost  output  1  arbitration lost during this command.
- bus_owned  output  1  START issued, no STOP yet.
- core_i2c_scl_in  input  1  SCL level from pad.
- core_i2c_scl_out  output  1  constant 0 (open-drain).
- core_i2c_scl_en  output  1  1 = pull SCL low, 0 = release.
- core_i2c_sda_in  input  1  SDA level from pad.
- core_i2c_sda_out  output  1  constant 0.
- core_i2c_sda_en  output  1  1 = pull SDA low, 0 = release.

Behaviour:
- **Reset (async, immediate):**
  - scl_en = sda_en = 0.
  - cmd_ready = 1; rsp_valid, rsp_err, arb_lost, ack_out, bus_owned = 0; rd_data = 0.
  - State IDLE; tick counter cleared.
  - Reset mid-byte releases both lines in the same cycle; no STOP is generated.
- **Handshake:**
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready drops the cycle after acceptance and stays 0 through the rsp_valid cycle.
  - cmd_ready rises the cycle after rsp_valid.
- **Tick generation:**
  - Counter runs 0..CLK_DIV-1; a quarter ends at count CLK_DIV-1.
  - In any quarter where SCL is released, the counter holds at 0 while core_i2c_scl_in == 0 (clock stretch). It starts counting the cycle after scl_in is seen high.
- **States:** IDLE, START, BIT, ACK, STOP, RESP. Each of START/BIT/ACK/STOP runs quarters Q0..Q3.
- **START** (legal anytime; repeated start allowed):
  - Q0: release SDA, SCL kept low if owned.
  - Q1: release SCL (stretch).
  - Q2: pull SDA low.
  - Q3: pull SCL low.
  - Then RESP, and bus_owned = 1.
- **WRITE/READ data bits**, 8 bits MSB first, each bit:
  - Q0: SCL low, SDA set (WRITE: en = ~bit; READ: released).
  - Q1: release SCL (stretch).
  - Q2: SCL high; sda_in sampled on the last cycle of Q2.
  - Q3: pull SCL low.
- **ACK bit:** same timing.
  - WRITE: SDA released; sample goes to ack_out.
  - READ: sda_en = ~ack_in.
- **STOP:**
  - Q0: SDA low.
  - Q1: release SCL (stretch).
  - Q2: release SDA.
  - Q3: idle, both released.
  - Then RESP; bus_owned = 0.
- **Illegal commands:** WRITE, READ or STOP with bus_owned == 0 generate no bus activity. rsp_valid with rsp_err = 1 is issued 1 cycle after accept.
- **Arbitration loss:**
  - Trigger: during a WRITE data bit with sda_en == 0, the Q2 sample reads 0.
  - Response: arb_lost = 1; both lines released the next cycle; bus_owned = 0; go to RESP.
- **RESP:** one cycle; rsp_valid = 1; flags valid only in this cycle; then IDLE.
- **Latency** with no stretch, measured from the accept cycle to rsp_valid:
  - START/STOP: 4*CLK_DIV + 1.
  - WRITE/READ: 36*CLK_DIV + 1.

Decomposition:
- Package verilab_i2c_pkg:
  - i2c_cmd_e (START/STOP/WRITE/READ).
  - i2c_state_e.
  - Quarter-index typedef.
  - Constant BITS_PER_BYTE = 8.
- Sub-module verilab_i2c_tick_gen:
  - Parameter CLK_DIV.
  - Inputs: enable, stretch_hold.
  - Outputs: quarter_done pulse, 2-bit quarter index.

Test Plan:
- Reset, START, then WRITE 0xA5 with the slave pulling SDA low in the ACK slot, CLK_DIV=4 → SDA at SCL-high samples reads 1,0,1,0,0,1,0,1; rsp ack_out=0; WRITE rsp 145 cycles after accept.
- START, READ with ack_in=1 while the bench drives 0x3C → rd_data=0x3C; sda_en=0 during ACK slot; then STOP → SDA rises while SCL high; bus_owned=0.
- Clock stretch: hold scl_in low for 20 cycles after the bit-3 SCL release → that bit lengthens by exactly 20 cycles; sample still taken at the end of Q2.
- Arbitration: WRITE 0xFF, force sda_in=0 at bit 6 Q2 → arb_lost=1; scl_en=sda_en=0 the next cycle; bus_owned=0.
- Illegal: WRITE with bus_owned=0 → rsp_valid 1 cycle after accept with rsp_err=1; no scl_en/sda_en activity.
- Assert reset_n low mid-WRITE at bit 4 → scl_en=sda_en=0 and cmd_ready=1 the same cycle; next command accepted normally after release.
